// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states, iteration count.
// The divide datapath is built only when MULDIV_DIV_EN is defined.
package muldiv_seq_pkg;
    localparam int MULDIV_W     = 16;
    localparam int MULDIV_ITERS = 16;

    localparam logic MULDIV_OP_MUL = 1'b0;
    localparam logic MULDIV_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_RUN  = 2'd1,
        MULDIV_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage control <-> multiply/divide sequencer handshake and result bundle.
interface muldiv_seq_if;
    logic        start;
    logic        op;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        flush;
    logic        stall;
    logic        done;
    logic [15:0] result;
    logic [15:0] resHi;
    logic        err;

    modport master (output start, op, opA, opB, flush,
                    input  stall, done, result, resHi, err);
    modport slave  (input  start, op, opA, opB, flush,
                    output stall, done, result, resHi, err);
endinterface

// File: rtl/muldiv_seq_add.sv
// 16-bit carry-lookahead adder (4-bit groups) with carry-out; shared by the
// multiply accumulate and the divide trial subtract.
module muldiv_seq_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [15:0] g, p;
    logic [3:0]  gg, pg;
    logic [16:0] c;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign gg[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        assign pg[k] = &p[4*k+3:4*k];
    end

    // Group carries come from group G/P; bits inside a group ripple off the group carry-in.
    always_comb begin
        c    = '0;
        c[0] = c_in;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++)
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            c[4*k+4] = gg[k] | (pg[k] & c[4*k]);
        end
    end

    assign sum   = p ^ c[15:0];
    assign c_out = c[16];
endmodule

// File: rtl/muldiv_seq.sv
// Iterative 16-bit shift-add multiplier / restoring divider with EX stall and flush abort.
// Divide support is compiled in with MULDIV_DIV_EN; otherwise op=1 completes at once with err.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    localparam logic [3:0] CNT_LAST = 4'(MULDIV_ITERS - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [15:0] hi, lo, mcand, hi_nx, lo_nx;
    logic [15:0] res_lo, res_hi;
    logic        res_err;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_ci, add_co;
    logic        accept, degen, last;

`ifdef MULDIV_DIV_EN
    logic op_q;
    logic no_borrow;
    assign degen = (bus.op == MULDIV_OP_DIV) && (bus.opB == '0);
    // 17-bit trial: shifted rem's top bit is hi[15]; it alone guarantees no borrow.
    assign no_borrow = hi[15] | add_co;
`else
    assign degen = (bus.op == MULDIV_OP_DIV);
`endif

    assign accept = (state == MULDIV_IDLE) && bus.start && !bus.flush;
    assign last   = (state == MULDIV_RUN) && (cnt == CNT_LAST);

    // hi/lo double as rem/quo and mcand as the divisor while dividing.
    always_comb begin
        add_a  = hi;
        add_b  = lo[0] ? mcand : '0;
        add_ci = 1'b0;
`ifdef MULDIV_DIV_EN
        if (op_q == MULDIV_OP_DIV) begin
            add_a  = {hi[14:0], lo[15]};
            add_b  = ~mcand;
            add_ci = 1'b1;
        end
`endif
    end

    muldiv_seq_add u_add (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_ci),
        .sum   (add_sum),
        .c_out (add_co)
    );

    always_comb begin
        hi_nx = {add_co, add_sum[15:1]};
        lo_nx = {add_sum[0], lo[15:1]};
`ifdef MULDIV_DIV_EN
        if (op_q == MULDIV_OP_DIV) begin
            hi_nx = no_borrow ? add_sum : add_a;
            lo_nx = {lo[14:0], no_borrow};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MULDIV_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            MULDIV_IDLE: if (accept) state_nx = degen ? MULDIV_DONE : MULDIV_RUN;
            MULDIV_RUN:  if (cnt == CNT_LAST) state_nx = MULDIV_DONE;
            MULDIV_DONE: state_nx = MULDIV_IDLE;
            default:     state_nx = MULDIV_IDLE;
        endcase
        if (bus.flush) state_nx = MULDIV_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       cnt <= '0;
        else if (accept)               cnt <= '0;
        else if (state == MULDIV_RUN)  cnt <= cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
`ifdef MULDIV_DIV_EN
            op_q  <= MULDIV_OP_MUL;
`endif
        end else if (accept) begin
            hi    <= '0;
`ifdef MULDIV_DIV_EN
            op_q  <= bus.op;
            lo    <= (bus.op == MULDIV_OP_DIV) ? bus.opA : bus.opB;
            mcand <= (bus.op == MULDIV_OP_DIV) ? bus.opB : bus.opA;
`else
            lo    <= bus.opB;
            mcand <= bus.opA;
`endif
        end else if (state == MULDIV_RUN) begin
            hi <= hi_nx;
            lo <= lo_nx;
        end
    end

    // Results load on the edge into DONE; a flush before that edge leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_lo  <= '0;
            res_hi  <= '0;
            res_err <= 1'b0;
        end else if (accept && degen) begin
`ifdef MULDIV_DIV_EN
            res_lo  <= 16'hFFFF;
            res_hi  <= bus.opA;
`else
            res_lo  <= '0;
            res_hi  <= '0;
`endif
            res_err <= 1'b1;
        end else if (last && !bus.flush) begin
            res_lo  <= lo_nx;
            res_hi  <= hi_nx;
            res_err <= 1'b0;
        end
    end

    assign bus.stall  = (state == MULDIV_RUN) || accept;
    assign bus.done   = (state == MULDIV_DONE) && !bus.flush;
    assign bus.result = res_lo;
    assign bus.resHi  = res_hi;
    assign bus.err    = res_err;
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative 16-bit multiply/divide sequencer that sits beside the execute stage. It accepts one operation from the EX-stage control. While the operation runs it holds the pipeline with a stall. It returns a 16-bit primary result and a 16-bit secondary result after a fixed number of cycles. Branch and jump redirects resolved in execute can abort it through a flush input.

## Interface
- No parameters; width fixed at 16 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide (unsigned)
- opA  input  16  multiplicand / dividend
- opB  input  16  multiplier / divisor
- flush  input  1  abort current operation (EX redirect)
- stall  output  1  freeze IF/ID/EX while the operation is pending
- done  output  1  one-cycle pulse: results valid
- result  output  16  product low half / quotient
- resHi  output  16  product high half / remainder
- err  output  1  divide-by-zero or unsupported op; valid with done

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start & ~flush and op is a legal non-degenerate operation. The operands are latched and cnt is set to 0.
- IDLE → DONE directly when start & ~flush and either opB == 0 with op = 1, or op = 1 with divide compiled out (see Configuration).
- RUN → DONE after cnt reaches 15, i.e. after 16 iteration cycles. cnt is 4 bits and increments once per RUN cycle.
- DONE → IDLE unconditionally.
- flush in any state forces IDLE on the next edge. Any in-flight operation is discarded.
- Multiply, shift-add:
  - Init: hi = 0, lo = opB, mcand = opA.
  - Each iteration: {c, sum} = hi + (lo[0] ? mcand : 0), a 17-bit add. Then {hi, lo} = {c, sum, lo} >> 1.
  - At completion: result = lo, resHi = hi, err = 0.
- Divide, unsigned restoring:
  - Init: rem = 0, quo = opA.
  - Each iteration: {rem, quo} <<= 1, then trial = rem − opB as a 17-bit subtract.
  - If no borrow, rem = trial and quo[0] = 1.
  - At completion: result = quo, resHi = rem, err = 0.
- Divide by zero: result = 16'hFFFF, resHi = opA, err = 1.
- start is ignored in RUN and DONE. op and operands are only sampled on accept.
- stall = (state == RUN) | (state == IDLE & start & ~flush). It is combinational, so the accepting cycle already stalls. stall is low in DONE so the held EX instruction retires with the result.
- done = (state == DONE) & ~flush.
- result, resHi and err are registered. They hold their value until the next accepted start.

## Timing
- Reset values: state = IDLE, cnt = 0, result = 0, resHi = 0, err = 0, done = 0, stall = 0. Reset mid-RUN aborts immediately and asynchronously.
- Normal operation: start accepted at edge T. The state is RUN for cycles T+1..T+16. done is high in cycle T+17. A new start is accepted no earlier than T+18, when the state is back in IDLE.
- Degenerate/illegal operation: accepted at T, done in cycle T+1.
- Throughput: one operation per 18 cycles.
- start and flush in the same cycle: flush wins; nothing is accepted and stall stays 0.
- Flush in DONE: done is suppressed and the state returns to IDLE. Results are still updated.

## Configuration
- MULDIV_DIV_EN defined: divide datapath and restoring logic are present.
- MULDIV_DIV_EN undefined: only multiply is built. op = 1 goes IDLE → DONE with result = 0, resHi = 0, err = 1.

## Structure
- Shared include file holds:
  - the op encodings (MULDIV_OP_MUL, MULDIV_OP_DIV);
  - the state encodings (MULDIV_IDLE, MULDIV_RUN, MULDIV_DONE);
  - the iteration count constant (16).
- A single adder sub-module instance, the existing cla_16 plus a carry-out bit, is shared between the multiply add and the divide subtract. The subtract uses an inverted operand with c_in = 1, and the borrow is the inverted carry-out.
- Top module is limited to the FSM, cnt, and the hi/lo/mcand registers.

## Test plan
- opA = 7, opB = 9, mul, start at T → stall high T..T+16, done at T+17 with result = 63, resHi = 0, err = 0.
- opA = opB = 16'hFFFF, mul → result = 16'h0001, resHi = 16'hFFFE.
- opA = 100, opB = 7, div → result = 14, resHi = 2, done at T+17. Also opA = 5, opB = 9 → result = 0, resHi = 5.
- opA = 42, opB = 0, div → done at T+1 with result = 16'hFFFF, resHi = 42, err = 1. Without MULDIV_DIV_EN the same stimulus gives result = 0, resHi = 0, err = 1.
- flush asserted in the 5th RUN cycle → IDLE next cycle, no done pulse, result unchanged. A following mul 3×4 gives 12.
- rst asserted mid-RUN, and a start issued while in RUN → all outputs return to 0 immediately and the start during RUN is ignored. start held together with flush in IDLE → never accepted.
